// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM period/duty measurement block.
package pwm_meas_pkg;

  localparam int CNT_W   = 16;
  localparam int SCNT_W  = 15;
  localparam int GPIO_W  = 8;
  localparam int SEL_W   = 3;
  localparam int SCALE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } meas_state_t;

  // Scale 0 yields an empty mask, so every cycle ticks.
  function automatic logic tick_hit(input logic [SCNT_W-1:0]  scnt,
                                    input logic [SCALE_W-1:0] scale);
    logic [SCNT_W-1:0] mask;
    mask = SCNT_W'((32'd1 << scale) - 32'd1);
    return &(scnt | ~mask);
  endfunction

endpackage

// File: rtl/pwm_meas_if.sv
// Configuration and result bundle of pwm_meas; master drives config and pads.
interface pwm_meas_if;
  import pwm_meas_pkg::*;

  logic [GPIO_W-1:0]  pad_gpio;
  logic               cfg_meas_enb;
  logic [SEL_W-1:0]   cfg_meas_gpio_sel;
  logic [SCALE_W-1:0] cfg_meas_scale;
  logic               cfg_meas_inv;
  logic               cfg_meas_oneshot;
  logic [CNT_W-1:0]   meas_high;
  logic [CNT_W-1:0]   meas_low;
  logic               meas_vld;
  logic               meas_done;
  logic               meas_ovflow;

  modport master (
    output pad_gpio, cfg_meas_enb, cfg_meas_gpio_sel, cfg_meas_scale,
           cfg_meas_inv, cfg_meas_oneshot,
    input  meas_high, meas_low, meas_vld, meas_done, meas_ovflow
  );

  modport slave (
    input  pad_gpio, cfg_meas_enb, cfg_meas_gpio_sel, cfg_meas_scale,
           cfg_meas_inv, cfg_meas_oneshot,
    output meas_high, meas_low, meas_vld, meas_done, meas_ovflow
  );

endinterface

// File: rtl/pwm_meas_sync.sv
// Pad synchronizer, polarity inversion and edge detector for pwm_meas.
// Define PWM_MEAS_GLITCH_FILTER_EN to require 3 equal samples before a level change.
module pwm_meas_sync
  import pwm_meas_pkg::*;
(
  input  logic              mclk,
  input  logic              h_reset_n,
  input  logic [GPIO_W-1:0] pad_gpio,
  input  logic [SEL_W-1:0]  gpio_sel,
  input  logic              inv,
  output logic              rise,
  output logic              fall
);

  logic sync_p0, sync_p1, cond_p2;
  logic level, cond_in;

  // Stage p0/p1: two-flop synchronizer on the selected pad
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pad_gpio[gpio_sel];
      sync_p1 <= sync_p0;
    end
  end

`ifdef PWM_MEAS_GLITCH_FILTER_EN
  logic hist_p2, hist_p3, filt_p4, filt_next;

  always_comb begin
    filt_next = filt_p4;
    if ((sync_p1 == hist_p2) && (hist_p2 == hist_p3))
      filt_next = sync_p1;
  end

  // Stage p2..p4: sample history and filtered level
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      hist_p2 <= 1'b0;
      hist_p3 <= 1'b0;
      filt_p4 <= 1'b0;
    end else begin
      hist_p2 <= sync_p1;
      hist_p3 <= hist_p2;
      filt_p4 <= filt_next;
    end
  end

  assign level = filt_next;
`else
  assign level = sync_p1;
`endif

  assign cond_in = level ^ inv;

  // Stage p2: conditioned level register for edge comparison
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) cond_p2 <= 1'b0;
    else            cond_p2 <= cond_in;
  end

  assign rise = cond_in & ~cond_p2;
  assign fall = ~cond_in & cond_p2;

endmodule

// File: rtl/pwm_meas.sv
// PWM measurement: counts prescaled ticks of active and inactive phases of a pad.
// Optional build macro PWM_MEAS_GLITCH_FILTER_EN (see pwm_meas_sync).
module pwm_meas
  import pwm_meas_pkg::*;
(
  input  logic       mclk,
  input  logic       h_reset_n,
  pwm_meas_if.slave  bus
);

  meas_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [SCNT_W-1:0] scnt;
  logic [CNT_W-1:0]  high_cap, low_cap;
  logic              vld_r, done_r, ovf_r;
  logic              rise, fall, tick;
  logic [CNT_W:0]    cnt_sum;
  logic              sat;
  logic [CNT_W-1:0]  cnt_nxt;

  // Returns {saturated, value}; value clamps at all ones.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                             input logic             inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{CNT_W{1'b0}}, inc};
    if (s[CNT_W]) return {1'b1, {CNT_W{1'b1}}};
    return s;
  endfunction

  pwm_meas_sync u_sync (
    .mclk      (mclk),
    .h_reset_n (h_reset_n),
    .pad_gpio  (bus.pad_gpio),
    .gpio_sel  (bus.cfg_meas_gpio_sel),
    .inv       (bus.cfg_meas_inv),
    .rise      (rise),
    .fall      (fall)
  );

  assign tick    = tick_hit(scnt, bus.cfg_meas_scale);
  assign cnt_sum = sat_add(cnt, tick);
  assign sat     = cnt_sum[CNT_W];
  assign cnt_nxt = cnt_sum[CNT_W-1:0];

  // Prescaler restarts on every edge so each phase is counted from its start
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n)
      scnt <= '0;
    else if (state == ST_IDLE || state == ST_ARM || rise || fall)
      scnt <= '0;
    else
      scnt <= scnt + SCNT_W'(1);
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      high_cap <= '0;
      low_cap  <= '0;
      vld_r    <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (!bus.cfg_meas_enb) begin
        state <= ST_IDLE;
        cnt   <= '0;
        vld_r <= 1'b0;
        ovf_r <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ARM;
            cnt   <= '0;
          end
          ST_ARM: begin
            if (rise) begin
              state <= ST_HIGH;
              cnt   <= '0;
            end
          end
          ST_HIGH: begin
            if (sat) ovf_r <= 1'b1;
            if (fall) begin
              high_cap <= cnt_nxt;
              cnt      <= '0;
              state    <= ST_LOW;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          ST_LOW: begin
            if (sat) ovf_r <= 1'b1;
            if (rise) begin
              low_cap <= cnt_nxt;
              cnt     <= '0;
              done_r  <= 1'b1;
              vld_r   <= 1'b1;
              state   <= bus.cfg_meas_oneshot ? ST_DONE : ST_HIGH;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          ST_DONE: state <= ST_DONE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.meas_high   = high_cap;
  assign bus.meas_low    = low_cap;
  assign bus.meas_vld    = vld_r;
  assign bus.meas_done   = done_r;
  assign bus.meas_ovflow = ovf_r;

endmodule
